mult_dispatcher: RTL

MULT_DISPATCHER -- requirements
Module: mult_dispatcher

---
 rtl/mult_dispatcher_if.sv | 44 ++++
 rtl/mult_dispatcher.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mult_dispatcher_if.sv
// Bundle of the three handshakes around the multiplier dispatcher:
// the operand input stream, the sequential-multiplier side and the result output.
//
// Handshake semantics:
//   in_valid/in_ready: the producer holds in_valid and the operands stable until it
//   sees in_ready. A pair transfers on every rising edge where both are high.
//   in_ready does not depend on in_valid.
//   mul_start/mul_ready: mul_start is a single-cycle pulse. mul_ready is a level.
//   The multiplier signals completion by taking mul_ready from low to high while
//   mul_product holds the result.
//   res_valid/res_ack: the dispatcher holds res_valid and res_product until the
//   consumer raises res_ack. The result is released on the rising edge where both
//   are high. res_ack has no effect while res_valid is low.
interface mult_dispatcher_if #(
  parameter int DP_WIDTH = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DP_WIDTH-1:0]   in_multiplier;
  logic [DP_WIDTH-1:0]   in_multiplicand;
  logic                  mul_start;
  logic [DP_WIDTH-1:0]   mul_multiplier;
  logic [DP_WIDTH-1:0]   mul_multiplicand;
  logic [2*DP_WIDTH-1:0] mul_product;
  logic                  mul_ready;
  logic                  res_valid;
  logic [2*DP_WIDTH-1:0] res_product;
  logic                  res_ack;
  logic                  busy;

  // Dispatcher side
  modport slave (
    input  in_valid, in_multiplier, in_multiplicand, mul_product, mul_ready, res_ack,
    output in_ready, mul_start, mul_multiplier, mul_multiplicand, res_valid, res_product,
           busy
  );

  // Environment side: operand producer, multiplier and result consumer
  modport master (
    output in_valid, in_multiplier, in_multiplicand, mul_product, mul_ready, res_ack,
    input  in_ready, mul_start, mul_multiplier, mul_multiplicand, res_valid, res_product,
           busy
  );
endinterface

// File: rtl/mult_dispatcher.sv
// Operand FIFO in front of an external sequential multiplier. Each queued pair
// is issued in order, one at a time. The product is captured on a fresh rising
// edge of mul_ready, then held until the consumer acknowledges it.
module mult_dispatcher #(
  parameter int DP_WIDTH = 5,
  parameter int DEPTH    = 4
) (
  input  logic             clk,
  input  logic             reset,
  mult_dispatcher_if.slave bus,
  output logic [1:0]       dbg_state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t state;
  state_t next_state;

  logic [DP_WIDTH-1:0]   fifo_a [DEPTH];
  logic [DP_WIDTH-1:0]   fifo_b [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;

  logic                  load;
  logic                  start_set;
  logic                  capture;
  logic                  release_res;

  logic [DP_WIDTH-1:0]   op_a;
  logic [DP_WIDTH-1:0]   op_b;
  logic                  start_q;
  logic                  ready_q;
  logic                  ready_qq;
  logic                  ready_rise;
  logic                  res_valid_q;
  logic [2*DP_WIDTH-1:0] res_q;

  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign push       = bus.in_valid & ~full;
  assign pop        = load;
  assign ready_rise = ready_q & ~ready_qq;

  // Operand storage; contents only matter where count says they are valid
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a[wr_ptr] <= bus.in_multiplier;
      fifo_b[wr_ptr] <= bus.in_multiplicand;
    end
  end

  // Wrap-around pointers and occupancy; push and pop on the same edge cancel out
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // FSM next state and one-cycle control strobes
  always_comb begin
    next_state  = state;
    load        = 1'b0;
    start_set   = 1'b0;
    capture     = 1'b0;
    release_res = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          load       = 1'b1;
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        start_set  = 1'b1;
        next_state = WAIT;
      end
      WAIT: begin
        if (ready_rise) begin
          capture    = 1'b1;
          next_state = HOLD;
        end
      end
      HOLD: begin
        if (bus.res_ack && res_valid_q) begin
          release_res = 1'b1;
          next_state  = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Issue registers: operands held from the pop until the next pop; start is
  // registered so it appears in the first WAIT cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_a    <= '0;
      op_b    <= '0;
      start_q <= 1'b0;
    end else begin
      if (load) begin
        op_a <= fifo_a[rd_ptr];
        op_b <= fifo_b[rd_ptr];
      end
      start_q <= start_set;
    end
  end

  // mul_ready history. The older sample is forced high when leaving ISSUE so a
  // level that was already high before the start pulse cannot look like a rise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_q  <= 1'b0;
      ready_qq <= 1'b0;
    end else begin
      ready_q  <= bus.mul_ready;
      ready_qq <= start_set ? 1'b1 : ready_q;
    end
  end

  // Result register: loaded on capture, held through HOLD, released on ack
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_valid_q <= 1'b0;
      res_q       <= '0;
    end else begin
      if (capture) begin
        res_valid_q <= 1'b1;
        res_q       <= bus.mul_product;
      end else if (release_res) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready         = ~full;
  assign bus.mul_start        = start_q;
  assign bus.mul_multiplier   = op_a;
  assign bus.mul_multiplicand = op_b;
  assign bus.res_valid        = res_valid_q;
  assign bus.res_product      = res_q;
  assign bus.busy             = (state != IDLE) | ~empty;
  assign dbg_state            = state;

endmodule
